// File: rtl/bus_region_pkg.sv
// Shared types and constants for the bus region controller.
package bus_region_pkg;

  // Controller states: idle decode, fixed wait count, device handshake.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HSHK = 2'd2
  } state_e;

  // Wait/timeout counter width; fits the largest handshake timeout.
  localparam int CNT_W = 10;

  // Slot index width; WAITS and HS_MASK describe up to 8 slots.
  localparam int SLOT_W = 3;

  // The IO region always sits in the slot just above the memory regions.
  function automatic logic [SLOT_W-1:0] io_slot(input int nreg);
    return SLOT_W'(nreg);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Loadable down-counter shared by the fixed-wait and handshake states.
module bus_wait_timer
  import bus_region_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; otherwise count down while enabled, holding at zero.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bus_region_ctrl.sv
// Address decode, chip selects, read-data mux and cpu_clken stall control
// for NREG equal memory regions plus one IO region.
module bus_region_ctrl
  import bus_region_pkg::*;
#(
  parameter int               ASIZE    = 20,
  parameter int               DSIZE    = 32,
  parameter int               NREG     = 4,
  parameter logic [31:0]      WAITS    = 32'h0000_0001,
  parameter logic [7:0]       HS_MASK  = 8'b0000_0100,
  parameter int               TMO      = 255,
  parameter logic [DSIZE-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vpa,
  input  logic                  vda,
  input  logic                  vio,
  input  logic                  rnw,
  input  logic [ASIZE-1:0]      address,
  input  logic [NREG*DSIZE-1:0] dev_rdata,
  input  logic [DSIZE-1:0]      io_rdata,
  input  logic [NREG:0]         dev_ack,
  input  logic                  err_clr,
  output logic [NREG-1:0]       cs_b,
  output logic                  io_cs_b,
  output logic [DSIZE-1:0]      cpu_din,
  output logic                  cpu_clken,
  output logic                  timeout_err
);

  localparam int                RBITS   = $clog2(NREG);
  localparam logic [SLOT_W-1:0] IO_SLOT = io_slot(NREG);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] sel, sel_q, sel_d;
  logic              access;
  logic [3:0]        wait_cnt;
  logic              use_hs;
  logic [7:0]        ack_pad;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0]  tmr_val;
  logic              timeout;
  logic              clken;

  // rnw is reserved for future write-only wait modes; low address bits only
  // matter to the devices themselves.
  logic unused_in;
  assign unused_in = ^{rnw, address[ASIZE-RBITS-1:0]};

  // Current-cycle decode; the CPU holds these stable while stalled.
  assign access   = vio | vpa | vda;
  assign sel      = vio ? IO_SLOT : SLOT_W'(address[ASIZE-1 -: RBITS]);
  assign wait_cnt = WAITS[{sel, 2'b00} +: 4];
  assign use_hs   = HS_MASK[sel];
  assign ack_pad  = 8'(dev_ack);

  bus_wait_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // State and latched slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state, stall and timer control.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    clken    = 1'b1;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (use_hs) begin
            if (!ack_pad[sel]) begin
              clken    = 1'b0;
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(TMO - 1);
              sel_d    = sel;
              state_d  = HSHK;
            end
          end else if (wait_cnt != 4'd0) begin
            clken    = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(wait_cnt - 4'd1);
            sel_d    = sel;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (!access || tmr_zero) begin
          state_d = IDLE;
        end else begin
          clken  = 1'b0;
          tmr_en = 1'b1;
        end
      end
      HSHK: begin
        if (!access || ack_pad[sel_q]) begin
          state_d = IDLE;
        end else if (tmr_zero) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          clken  = 1'b0;
          tmr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset releases the CPU immediately and suppresses any error.
    if (reset) begin
      clken   = 1'b1;
      timeout = 1'b0;
    end
  end

  assign cpu_clken = clken;

  // Sticky timeout flag; a new timeout wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (timeout) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

  // Active-low chip selects from the current decode.
  always_comb begin
    cs_b = '1;
    for (int r = 0; r < NREG; r++) begin
      cs_b[r] = !(!vio && (vpa || vda) && (sel == SLOT_W'(r)));
    end
  end

  assign io_cs_b = !vio;

  // Read-data mux by slot, forced to ERR_DATA in the timeout cycle.
  always_comb begin
    cpu_din = io_rdata;
    for (int r = 0; r < NREG; r++) begin
      if (sel == SLOT_W'(r)) cpu_din = dev_rdata[DSIZE*r +: DSIZE];
    end
    if (timeout) cpu_din = ERR_DATA;
  end

endmodule

// File: tb/tb_bus_region_ctrl.sv
// Scoreboard bench for bus_region_ctrl: region0 0 waits, region1 3 waits,
// region2 handshake (TMO 8), region3 2 waits, IO 1 wait.
module tb_bus_region_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         vpa, vda, vio, rnw;
  logic [19:0]  address;
  logic [127:0] dev_rdata;
  logic [31:0]  io_rdata;
  logic [4:0]   dev_ack;
  logic         err_clr;
  logic [3:0]   cs_b;
  logic         io_cs_b;
  logic [31:0]  cpu_din;
  logic         cpu_clken;
  logic         timeout_err;

  always #5 clk = ~clk;

  bus_region_ctrl #(
    .ASIZE(20), .DSIZE(32), .NREG(4),
    .WAITS(32'h0001_2030), .HS_MASK(8'b0000_0100),
    .TMO(8), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset), .vpa(vpa), .vda(vda), .vio(vio), .rnw(rnw),
    .address(address), .dev_rdata(dev_rdata), .io_rdata(io_rdata),
    .dev_ack(dev_ack), .err_clr(err_clr), .cs_b(cs_b), .io_cs_b(io_cs_b),
    .cpu_din(cpu_din), .cpu_clken(cpu_clken), .timeout_err(timeout_err)
  );

  typedef struct {
    string       tag;
    int          cycles;
    logic [31:0] data;
    logic [3:0]  cs;
    logic        io_cs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mon_cyc  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: checks selects every access cycle, pops on completion.
  always @(negedge clk) begin
    if (reset || !(vio | vpa | vda)) begin
      mon_cyc = 0;
    end else begin
      mon_cyc++;
      if (exp_q.size() != 0) begin
        check({exp_q[0].tag, "_cs_b"}, 32'(cs_b), 32'(exp_q[0].cs));
        check({exp_q[0].tag, "_io_cs_b"}, 32'(io_cs_b), 32'(exp_q[0].io_cs));
      end
      if (cpu_clken) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.tag, "_cycles"}, 32'(mon_cyc), 32'(e.cycles));
          check({e.tag, "_din"}, cpu_din, e.data);
        end
        mon_cyc = 0;
      end
    end
  end

  // Drive one access starting just after a posedge; returns just after the
  // posedge that ends it. ack_mask is applied on cycle ack_at only, err_clr
  // on cycle clr_at only.
  task automatic access(input string tag, input logic [19:0] addr,
                        input logic [2:0] ctl, input logic [4:0] ack_mask,
                        input int ack_at, input int clr_at, input int cycles,
                        input logic [31:0] data, input logic [3:0] cs,
                        input logic io_cs, input logic err);
    exp_t e;
    bit   done = 1'b0;
    e.tag = tag; e.cycles = cycles; e.data = data; e.cs = cs; e.io_cs = io_cs;
    exp_q.push_back(e);
    address = addr;
    {vio, vpa, vda} = ctl;
    for (int c = 1; c <= 40 && !done; c++) begin
      dev_ack = (c == ack_at) ? ack_mask : 5'd0;
      err_clr = (c == clr_at);
      @(negedge clk);
      if (cpu_clken) done = 1'b1;
      @(posedge clk); #1;
    end
    dev_ack = '0;
    err_clr = 1'b0;
    if (!done) check({tag, "_bound"}, 32'd0, 32'd1);
    check({tag, "_err"}, 32'(timeout_err), 32'(err));
  endtask

  task automatic idle(input int n);
    {vio, vpa, vda} = 3'b000;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check(tag, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {vio, vpa, vda} = 3'b000;
    rnw = 1'b1;
    address = '0;
    dev_rdata = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    io_rdata = 32'hC0DE_0010;
    dev_ack = '0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_clken", 32'(cpu_clken), 32'd1);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_cs_b", 32'(cs_b), 32'hF);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // Fixed waits: 0, 3, 2 and program fetch.
    access("r0_zero", 20'h00010, 3'b001, 5'd0, 0, 0, 1, 32'hD0D0_0000, 4'b1110, 1'b1, 1'b0);
    access("r1_w3",   20'h40000, 3'b001, 5'd0, 0, 0, 4, 32'hD1D1_0001, 4'b1101, 1'b1, 1'b0);
    idle(1);
    access("r3_fetch", 20'hC1234, 3'b010, 5'd0, 0, 0, 3, 32'hD3D3_0003, 4'b0111, 1'b1, 1'b0);
    // Back-to-back identical addresses are separate accesses.
    access("r1_b2b_a", 20'h40004, 3'b001, 5'd0, 0, 0, 4, 32'hD1D1_0001, 4'b1101, 1'b1, 1'b0);
    access("r1_b2b_b", 20'h40004, 3'b001, 5'd0, 0, 0, 4, 32'hD1D1_0001, 4'b1101, 1'b1, 1'b0);
    idle(1);

    // Handshake: ack on cycle 5, ack on cycle 1.
    access("r2_ack5", 20'h80000, 3'b001, 5'b00100, 5, 0, 5, 32'hD2D2_0002, 4'b1011, 1'b1, 1'b0);
    access("r2_ack1", 20'h80040, 3'b001, 5'b00100, 1, 0, 1, 32'hD2D2_0002, 4'b1011, 1'b1, 1'b0);
    idle(1);

    // Timeout; an ack on another region's bit must not complete it.
    access("r2_tmo", 20'h80000, 3'b001, 5'b00010, 2, 0, 9, 32'hDEAD_BEEF, 4'b1011, 1'b1, 1'b1);
    idle(2);
    check("err_sticky", 32'(timeout_err), 32'd1);
    clear_err("err_clr");
    // Clear in the same cycle as a new timeout: set wins.
    access("r2_tmo_clr", 20'h80000, 3'b001, 5'd0, 0, 9, 9, 32'hDEAD_BEEF, 4'b1011, 1'b1, 1'b1);
    idle(1);
    clear_err("err_clr2");

    // IO has priority over the memory decode.
    access("io_w1", 20'h40000, 3'b101, 5'd0, 0, 0, 2, 32'hC0DE_0010, 4'b1111, 1'b0, 1'b0);
    idle(1);

    // Access dropped mid-handshake: release, no error.
    address = 20'h80000;
    {vio, vpa, vda} = 3'b001;
    @(negedge clk);
    check("drop_stall", 32'(cpu_clken), 32'd0);
    @(posedge clk); #1;
    {vio, vpa, vda} = 3'b000;
    @(negedge clk);
    check("drop_clken", 32'(cpu_clken), 32'd1);
    @(posedge clk); #1;
    check("drop_err", 32'(timeout_err), 32'd0);
    access("after_drop", 20'h00020, 3'b001, 5'd0, 0, 0, 1, 32'hD0D0_0000, 4'b1110, 1'b1, 1'b0);
    idle(1);

    // Reset on cycle 2 of a 3-wait access.
    address = 20'h40000;
    {vio, vpa, vda} = 3'b001;
    @(negedge clk);
    check("rst_pre_stall", 32'(cpu_clken), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_clken", 32'(cpu_clken), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    access("post_rst", 20'h00010, 3'b001, 5'd0, 0, 0, 1, 32'hD0D0_0000, 4'b1110, 1'b1, 1'b0);
    idle(2);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
